// File: rtl/fp_div_arb_pkg.sv
// fp_div_arb_pkg: shared types and width helpers for the divider arbiter.
//   state_t    : arbiter FSM states
//   DATA_W_DEF : default operand/quotient width (IEEE-754 single)
//   idx_w()    : owner-index width for a given requester count
//   wd_w()     : watchdog counter width for a given timeout
package fp_div_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam int DATA_W_DEF = 32;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wd_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/fp_div_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req  : request vector
//   last : index of the most recent winner; search starts at last+1
//   gnt  : one-hot grant (zero when no request)
//   idx  : encoded index of the granted requester
module rr_arbiter
  import fp_div_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] c;

  // Walk the ring once starting just after the last winner; first hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    c   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = IW'((int'(last) + k) % NUM_REQ);
      if (gnt == '0 && req[c]) begin
        gnt[c] = 1'b1;
        idx    = c;
      end
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: shares one iterative FP divider among NUM_REQ requesters.
//   clock, resetn         : clock, synchronous active-low reset
//   req_valid/req_a/req_b : per-requester divide requests (flat operand slices)
//   req_ready             : one-hot accept, only while idle
//   resp_valid/resp_q     : one-cycle one-hot result pulse and quotient
//   flush_mask            : kill the owner's in-flight divide
//   err_timeout           : one-cycle pulse when the watchdog aborts
//   div_*                 : divider handshake (start pulse, ready pulse, quotient)
module fp_div_arbiter
  import fp_div_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_q,
  input  logic [NUM_REQ-1:0]        flush_mask,
  output logic                      err_timeout,
  output logic [DATA_W-1:0]         div_a,
  output logic [DATA_W-1:0]         div_b,
  output logic                      div_start,
  input  logic                      div_busy,
  input  logic                      div_ready,
  input  logic [DATA_W-1:0]         div_q
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int WW = wd_w(TIMEOUT);

  state_t              state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_q, last_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, q_q, q_d;
  logic [WW-1:0]       wd_q, wd_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       gnt_idx;
  logic                flush_own;

  // Busy is status only; sequencing relies solely on the ready pulse.
  logic busy_unused;
  assign busy_unused = div_busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign flush_own = flush_mask[owner_q];
  assign div_a     = a_q;
  assign div_b     = b_q;
  assign resp_q    = q_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    q_d         = q_q;
    wd_d        = wd_q;
    req_ready   = '0;
    resp_valid  = '0;
    div_start   = 1'b0;
    err_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        // No grant is advertised while reset is asserted.
        req_ready = resetn ? gnt : '0;
        if (|gnt) begin
          owner_d = gnt_idx;
          last_d  = gnt_idx;
          a_d     = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
          b_d     = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start = 1'b1;
        wd_d      = '0;
        state_d   = S_WAIT;
      end
      S_WAIT, S_DRAIN: begin
        // Watchdog keeps running through DRAIN so a flushed divide that
        // never returns still aborts on the original deadline.
        wd_d = wd_q + 1'b1;
        if (div_ready) begin
          if (state_q == S_WAIT && !flush_own) begin
            q_d     = div_q;
            state_d = S_RESP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          err_timeout = 1'b1;
          state_d     = S_IDLE;
        end else if (state_q == S_WAIT && flush_own) begin
          state_d = S_DRAIN;
        end
      end
      S_RESP: begin
        resp_valid[owner_q] = 1'b1;
        state_d             = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Bench for fp_div_arbiter: fixed-latency divider model, transaction-level
// timing model compared every cycle, plus hand-computed literal checks.
module tb_fp_div_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int TO = 64;
  localparam int L  = 5;

  logic           clock, resetn;
  logic [N-1:0]   req_valid, req_ready, resp_valid, flush_mask;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   resp_q, div_a, div_b, div_q;
  logic           err_timeout, div_start, div_busy, div_ready;

  fp_div_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_q(resp_q), .flush_mask(flush_mask), .err_timeout(err_timeout),
    .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_busy(div_busy),
    .div_ready(div_ready), .div_q(div_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit en      = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Divider reference for the operand pairs this bench uses.
  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    if (b[30:0] == 31'h0) return {a[31] ^ b[31], 8'hff, 23'h0};
    if (b == 32'h3f800000) return a;
    if (a == 32'h40c00000 && b == 32'h40000000) return 32'h40400000;
    return 32'h7fc00000;
  endfunction

  // Round-robin rule: first valid requester after the last winner.
  function automatic int rr(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // ---------------- divider model: ready pulse L cycles after start ----------
  int          dcnt = 0;
  bit          hang = 1'b0, spur = 1'b0;
  logic [31:0] dq_pend;

  initial begin
    div_ready = 1'b0; div_q = '0; div_busy = 1'b0; dq_pend = '0;
    forever begin
      @(negedge clock);
      if (div_start === 1'b1) begin dcnt = L; dq_pend = fdiv(div_a, div_b); end
      @(posedge clock); #2;
      div_ready = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0 && !hang) begin div_ready = 1'b1; div_q = dq_pend; end
      end
      if (spur) begin div_ready = 1'b1; div_q = 32'h12345678; end
      div_busy = (dcnt > 0);
    end
  end

  // ---------------- transaction-level model + per-cycle compare --------------
  bit          m_busy = 1'b0, m_killed = 1'b0, m_resolved = 1'b0;
  int          m_owner = 0, m_acc = 0, m_free_at = -1, m_resp_at = -1, m_last = N - 1;
  logic [31:0] m_q = '0, m_da = '0, m_db = '0;
  int          acc_idx[$], acc_cyc[$];
  int          start_cyc = -1, err_cyc = -1, resp_cnt = 0, resp_cyc = -1;
  logic [31:0] last_resp = '0;
  logic [N-1:0] last_rv = '0;

  always @(negedge clock) begin
    logic [N-1:0] e_rdy, e_resp;
    logic         e_start, e_err;
    logic [31:0]  n_q;
    int           g, age;
    cyc++;
    e_rdy = '0; e_resp = '0; e_start = 1'b0; e_err = 1'b0; n_q = m_q; g = -1;
    if (m_busy && cyc == m_free_at) m_busy = 1'b0;
    if (!m_busy) begin
      g = rr(req_valid, m_last);
      if (resetn && g >= 0) e_rdy[g] = 1'b1;
    end else begin
      e_start = (cyc == m_acc + 1);
      if (cyc == m_resp_at) e_resp[m_owner] = 1'b1;
      else if (!m_resolved && cyc >= m_acc + 2) begin
        age = cyc - m_acc - 1;
        if (div_ready) begin
          if (!m_killed && !flush_mask[m_owner]) begin
            n_q = div_q; m_resp_at = cyc + 1; m_free_at = cyc + 2;
          end else m_free_at = cyc + 1;
          m_resolved = 1'b1;
        end else if (age == TO) begin
          e_err = 1'b1; m_free_at = cyc + 1; m_resolved = 1'b1;
        end else if (flush_mask[m_owner]) m_killed = 1'b1;
      end
    end
    if (en) begin
      chk("req_ready",   req_ready,   e_rdy);
      chk("div_start",   div_start,   e_start);
      chk("resp_valid",  resp_valid,  e_resp);
      chk("err_timeout", err_timeout, e_err);
      chk("resp_q",      resp_q,      m_q);
      chk("div_a",       div_a,       m_da);
      chk("div_b",       div_b,       m_db);
      if (div_start)   start_cyc = cyc;
      if (err_timeout) err_cyc = cyc;
      if (|resp_valid) begin
        resp_cnt++; last_resp = resp_q; resp_cyc = cyc; last_rv = resp_valid;
      end
    end
    m_q = n_q;
    if (!m_busy && resetn && g >= 0) begin
      m_busy = 1'b1; m_owner = g; m_acc = cyc; m_last = g;
      m_da = req_a[g*W +: W]; m_db = req_b[g*W +: W];
      m_killed = 1'b0; m_resolved = 1'b0; m_resp_at = -1; m_free_at = -1;
      acc_idx.push_back(g); acc_cyc.push_back(cyc);
    end
    if (!resetn) begin
      m_busy = 1'b0; m_last = N - 1; m_q = '0; m_da = '0; m_db = '0; en = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Hold request i until accepted (bounded), then drop it.
  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_valid[i] = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clock);
      if (req_ready[i]) ok = 1'b1;
    end
    tick();
    req_valid[i] = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_wait req%0d: got no accept, required accept within 200 cycles", i);
    end
  endtask

  initial begin
    int base, rc, ec;
    resetn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; flush_mask = '0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // single request: -2 / -0 = +inf
    do_req(0, 32'hc0000000, 32'h80000000);
    repeat (10) tick();
    chk("t1_resp_q",   last_resp, 32'h7f800000);
    chk("t1_latency",  resp_cyc - acc_cyc[acc_cyc.size()-1], 7);
    chk("t1_resp_vld", last_rv, 2'b01);

    // both requesters always valid: grants alternate, 8-cycle spacing
    base = acc_idx.size();
    req_a = {2{32'h40400000}}; req_b = {2{32'h3f800000}};
    req_valid = 2'b11;
    for (int k = 0; k < 100 && acc_idx.size() < base + 4; k++) tick();
    req_valid = '0;
    repeat (10) tick();
    chk("t2_grant0", acc_idx[base],   1);
    chk("t2_grant1", acc_idx[base+1], 0);
    chk("t2_grant2", acc_idx[base+2], 1);
    chk("t2_grant3", acc_idx[base+3], 0);
    for (int j = 0; j < 3; j++) chk("t2_spacing", acc_cyc[base+j+1] - acc_cyc[base+j], 8);
    chk("t2_resp_q", last_resp, 32'h40400000);

    // owner flush at T+3: no response, next accept right after the drained ready
    rc = resp_cnt; base = acc_cyc.size();
    do_req(0, 32'h40c00000, 32'h40000000);
    tick();
    tick();
    flush_mask = 2'b01;
    req_a[W +: W] = 32'h40c00000; req_b[W +: W] = 32'h40000000; req_valid[1] = 1'b1;
    tick();
    flush_mask = '0;
    do_req(1, 32'h40c00000, 32'h40000000);
    repeat (10) tick();
    chk("t3_accept_gap", acc_cyc[base+1] - acc_cyc[base], 7);
    chk("t3_resp_cnt",   resp_cnt - rc, 1);
    chk("t3_resp_vld",   last_rv, 2'b10);
    chk("t3_resp_q",     last_resp, 32'h40400000);

    // non-owner flush is ignored
    rc = resp_cnt;
    do_req(0, 32'h40c00000, 32'h40000000);
    tick();
    tick();
    flush_mask = 2'b10;
    tick();
    flush_mask = '0;
    repeat (8) tick();
    chk("t3b_resp_cnt", resp_cnt - rc, 1);
    chk("t3b_resp_vld", last_rv, 2'b01);

    // hung divider: abort exactly TIMEOUT cycles after the start pulse
    hang = 1'b1; ec = err_cyc;
    do_req(1, 32'h40c00000, 32'h40000000);
    repeat (70) tick();
    hang = 1'b0;
    chk("t4_err_seen", err_cyc > ec, 1);
    chk("t4_err_gap",  err_cyc - start_cyc, 64);
    rc = resp_cnt;
    do_req(0, 32'h40400000, 32'h3f800000);
    repeat (9) tick();
    chk("t4_next_resp", resp_cnt - rc, 1);
    chk("t4_next_q",    last_resp, 32'h40400000);

    // reset mid-divide: outputs cleared, late ready ignored, then normal service
    do_req(0, 32'h40c00000, 32'h40000000);
    tick();
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rc = resp_cnt;
    @(negedge clock);
    chk("t5_div_a_clr",  div_a, 32'h0);
    chk("t5_resp_q_clr", resp_q, 32'h0);
    tick();
    repeat (6) tick();
    chk("t5_no_late_resp", resp_cnt - rc, 0);
    do_req(1, 32'h40c00000, 32'h40000000);
    repeat (9) tick();
    chk("t5_new_resp", resp_cnt - rc, 1);
    chk("t5_new_vld",  last_rv, 2'b10);

    // spurious ready while idle
    rc = resp_cnt;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (3) tick();
    chk("t6_no_resp", resp_cnt - rc, 0);
    @(negedge clock);
    chk("t6_resp_q_held", resp_q, 32'h40400000);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
